uart_receiver: RTL and testbench

UART serial receiver for the 9600-baud link. It deserialises 8N1 frames from the rx line using the 16x oversampling tick produced by the baud rate generator's receive enable. Each completed byte is presented on a parallel output and held until the consumer clears it, with framing-error and overrun status. It sits between the board rx pin and the UART host-side logic. It is the receive-side counterpart of the UART transmitter.

---
 rtl/uart_receiver_if.sv | 38 +++
 rtl/uart_receiver.sv | 174 +++++++++++++++++
 tb/tb_uart_receiver.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_receiver_if.sv
// uart_receiver_if
// Host-side bundle of the UART receiver: the received byte, its status
// flags and the consumer's acknowledge.
//   rd_clr     consumer -> receiver, 1-clock acknowledge pulse
//   rx_data    receiver -> consumer, last correctly framed byte
//   rx_ready   receiver -> consumer, byte waiting to be read
//   frame_err  receiver -> consumer, last frame had a low stop bit
//   overrun    receiver -> consumer, unread byte was overwritten
//   busy       receiver -> consumer, a frame is being received
// modport slave is taken by the receiver, modport master by the consumer.
interface uart_receiver_if #(
  parameter int DATA_BITS = 8
);
  logic                 rd_clr;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;

  modport slave (
    input  rd_clr,
    output rx_data,
    output rx_ready,
    output frame_err,
    output overrun,
    output busy
  );

  modport master (
    output rd_clr,
    input  rx_data,
    input  rx_ready,
    input  frame_err,
    input  overrun,
    input  busy
  );
endinterface

// File: rtl/uart_receiver.sv
// uart_receiver
// 8N1 UART receiver driven by a 16x oversampling tick. The rx pin is
// synchronised, a falling edge starts a frame, the start bit is confirmed
// at mid-bit, data bits are sampled LSB first one bit period apart, and the
// stop bit decides between delivering the byte and flagging a framing error.
// Ports:
//   clock   system clock
//   reset   synchronous, active-high
//   enb_rx  1-clock pulse at OVERSAMPLE x baud; all bit timing counts these
//   rx      asynchronous serial line, idle high
//   host    uart_receiver_if.slave: rd_clr in; rx_data, rx_ready,
//           frame_err, overrun, busy out
module uart_receiver #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enb_rx,
  input  logic            rx,
  uart_receiver_if.slave  host
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int IDX_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TICK_W-1:0] MID_TICK = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] END_TICK = TICK_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t               state, state_next;
  logic [TICK_W-1:0]    tick_cnt, tick_next;
  logic [IDX_W-1:0]     bit_idx, idx_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 good_stop, bad_stop;

  logic rx_meta, rx_sync, rx_prev;

  // Two-flop synchroniser plus one history flop for falling-edge detection.
  // Reset to the idle level so leaving reset never looks like a start edge
  // while the line is high.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // FSM state and bit-timing counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      state     <= state_next;
      tick_cnt  <= tick_next;
      bit_idx   <= idx_next;
      shift_reg <= shift_next;
    end
  end

  // Next-state logic. The start edge is looked for on every clock, but all
  // counting and sampling happens only on enb_rx ticks, so a low enb_rx
  // simply freezes the frame in progress.
  always_comb begin
    state_next = state;
    tick_next  = tick_cnt;
    idx_next   = bit_idx;
    shift_next = shift_reg;
    good_stop  = 1'b0;
    bad_stop   = 1'b0;
    case (state)
      IDLE: begin
        if (rx_prev && !rx_sync) begin
          state_next = START;
          tick_next  = '0;
        end
      end
      START: begin
        if (enb_rx) begin
          if (tick_cnt == MID_TICK) begin
            // A line back high at mid start bit was only a glitch.
            state_next = rx_sync ? IDLE : DATA;
            tick_next  = '0;
            idx_next   = '0;
          end else begin
            tick_next = tick_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (enb_rx) begin
          if (tick_cnt == END_TICK) begin
            // Bits arrive LSB first, so shifting in at the top leaves the
            // first bit at bit 0 after the last shift.
            shift_next = {rx_sync, shift_reg[DATA_BITS-1:1]};
            tick_next  = '0;
            idx_next   = bit_idx + 1'b1;
            if (bit_idx == LAST_IDX) begin
              state_next = STOP;
              idx_next   = '0;
            end
          end else begin
            tick_next = tick_cnt + 1'b1;
          end
        end
      end
      STOP: begin
        if (enb_rx) begin
          if (tick_cnt == END_TICK) begin
            good_stop  = rx_sync;
            bad_stop   = !rx_sync;
            state_next = IDLE;
            tick_next  = '0;
          end else begin
            tick_next = tick_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        tick_next  = '0;
        idx_next   = '0;
      end
    endcase
  end

  // Host-side status. A good completion takes priority over a coincident
  // rd_clr: the new byte is presented and rx_ready stays set, but the
  // acknowledge still counts as having read the previous byte, so it
  // suppresses the overrun.
  always_ff @(posedge clock) begin
    if (reset) begin
      host.rx_data   <= '0;
      host.rx_ready  <= 1'b0;
      host.frame_err <= 1'b0;
      host.overrun   <= 1'b0;
    end else if (good_stop) begin
      host.rx_data   <= shift_reg;
      host.rx_ready  <= 1'b1;
      host.frame_err <= 1'b0;
      if (host.rd_clr) begin
        host.overrun <= 1'b0;
      end else if (host.rx_ready) begin
        host.overrun <= 1'b1;
      end
    end else begin
      if (host.rd_clr) begin
        host.rx_ready <= 1'b0;
        host.overrun  <= 1'b0;
      end
      if (bad_stop) begin
        host.frame_err <= 1'b1;
      end
    end
  end

  assign host.busy = (state != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver
// Self-checking bench for uart_receiver. enb_rx pulses every 4 clocks, so
// one bit period is 64 clocks. Frames are described in a table; expected
// host-side results are queued when a frame is driven and compared once
// the receiver has gone idle. Glitch, rd_clr and mid-frame reset cases are
// written out by hand.
`timescale 1ns/1ps
module tb_uart_receiver;

  localparam int BIT_CLKS  = 64;
  localparam int DONE_TICK = 152;

  logic clock;
  logic reset;
  logic enb_rx;
  logic rx;

  uart_receiver_if #(.DATA_BITS(8)) host_if ();

  uart_receiver #(
    .DATA_BITS  (8),
    .OVERSAMPLE (16)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .enb_rx (enb_rx),
    .rx     (rx),
    .host   (host_if)
  );

  typedef struct {
    bit         pre_reset;
    bit         pre_clr;
    logic [7:0] data;
    bit         stop_bit;
    bit         clr_done;
    int         break_bits;
    logic [7:0] exp_data;
    bit         exp_ready;
    bit         exp_ferr;
    bit         exp_ovr;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    bit         ready;
    bit         ferr;
    bit         ovr;
  } exp_t;

  vec_t vecs [8];
  exp_t exp_q [$];

  int total = 0;
  int bad   = 0;
  int phase = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hard stop in case something keeps the bench from reaching its summary.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic compare(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Advance to the next falling edge and drive the baud tick for that cycle.
  task automatic step();
    @(negedge clock);
    enb_rx = (phase == 0);
    phase  = (phase + 1) % 4;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) step();
  endtask

  // Drive one 8N1 frame. Counts the baud ticks the receiver will see after
  // its synchroniser delay so rd_clr can be placed on the completion clock.
  // A non-negative abort_at asserts reset at that step and returns early.
  task automatic send_frame(input logic [7:0] d, input bit stop_b, input bit clr_done,
                            input int abort_at, output int done_step, output int rise_step);
    logic [9:0] bits;
    int         ticks;
    logic       prev_ready;
    bits       = {stop_b, d, 1'b0};
    ticks      = 0;
    done_step  = -1;
    rise_step  = -1;
    prev_ready = host_if.rx_ready;
    for (int s = 0; s < 10 * BIT_CLKS; s++) begin
      step();
      if (s == abort_at) begin
        reset          = 1'b1;
        rx             = 1'b1;
        host_if.rd_clr = 1'b0;
        return;
      end
      rx = bits[s / BIT_CLKS];
      if (rise_step < 0 && host_if.rx_ready && !prev_ready) rise_step = s;
      prev_ready = host_if.rx_ready;
      if (s >= 3 && enb_rx) ticks++;
      host_if.rd_clr = clr_done && enb_rx && (ticks == DONE_TICK);
      if (enb_rx && ticks == DONE_TICK && done_step < 0) done_step = s;
    end
    step();
    host_if.rd_clr = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 200 && host_if.busy; k++) step();
    compare(name, host_if.busy, 0);
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    int   done_s, rise_s;
    bit   was_ready;
    if (v.pre_reset) begin
      step(); reset = 1'b1;
      step(); reset = 1'b0;
    end
    if (v.pre_clr) begin
      step(); host_if.rd_clr = 1'b1;
      step(); host_if.rd_clr = 1'b0;
    end
    idle(20);
    was_ready = host_if.rx_ready;
    e.data  = v.exp_data;
    e.ready = v.exp_ready;
    e.ferr  = v.exp_ferr;
    e.ovr   = v.exp_ovr;
    exp_q.push_back(e);
    send_frame(v.data, v.stop_bit, v.clr_done, -1, done_s, rise_s);
    if (v.exp_ready && !was_ready) compare("ready_rise_step", rise_s, done_s + 1);
    wait_idle("busy_after_frame");
    if (v.break_bits > 0) begin
      rx = 1'b0;
      repeat (v.break_bits * BIT_CLKS) step();
      compare("no_start_in_break", host_if.busy, 0);
      idle(BIT_CLKS);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (exp_q.size() == 0) begin
      compare("scoreboard_empty", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    compare("rx_data",   host_if.rx_data,   e.data);
    compare("rx_ready",  host_if.rx_ready,  e.ready);
    compare("frame_err", host_if.frame_err, e.ferr);
    compare("overrun",   host_if.overrun,   e.ovr);
  endtask

  task automatic check_all_zero(input string tag);
    compare({tag, "_rx_data"},   host_if.rx_data,   0);
    compare({tag, "_rx_ready"},  host_if.rx_ready,  0);
    compare({tag, "_frame_err"}, host_if.frame_err, 0);
    compare({tag, "_overrun"},   host_if.overrun,   0);
    compare({tag, "_busy"},      host_if.busy,      0);
  endtask

  initial begin
    int d_s, r_s;

    //           rst clr data   stop cdone brk  exp_data rdy ferr ovr
    vecs[0] = '{1, 0, 8'hA5, 1, 0, 0, 8'hA5, 1, 0, 0};
    vecs[1] = '{1, 0, 8'h3C, 0, 0, 3, 8'h00, 0, 1, 0};
    vecs[2] = '{0, 0, 8'h55, 1, 0, 0, 8'h55, 1, 0, 0};
    vecs[3] = '{0, 1, 8'h11, 1, 0, 0, 8'h11, 1, 0, 0};
    vecs[4] = '{0, 0, 8'h22, 1, 0, 0, 8'h22, 1, 0, 1};
    vecs[5] = '{0, 0, 8'h01, 1, 0, 0, 8'h01, 1, 0, 0};
    vecs[6] = '{0, 0, 8'h7E, 1, 1, 0, 8'h7E, 1, 0, 0};
    vecs[7] = '{0, 0, 8'hFF, 1, 0, 0, 8'hFF, 1, 0, 0};

    reset          = 1'b1;
    rx             = 1'b1;
    enb_rx         = 1'b0;
    host_if.rd_clr = 1'b0;
    repeat (3) step();
    check_all_zero("reset");
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin
        // Reset pulse in the middle of data bit 4 of a frame; everything
        // clears and the line then idles before the next frame.
        idle(20);
        send_frame(8'h00, 1'b1, 1'b0, 5 * BIT_CLKS + 20, d_s, r_s);
        step();
        reset = 1'b0;
        check_all_zero("midframe_reset");
        idle(2 * BIT_CLKS);
      end
      applyStimulus(vecs[i]);
      checkOutput();
      if (i == 0) begin
        // Short low pulse: START must abort at its mid-bit sample.
        rx = 1'b0;
        for (int s = 0; s < BIT_CLKS; s++) begin
          step();
          if (s == 16) rx = 1'b1;
          if (s == 12) compare("glitch_busy_high", host_if.busy, 1);
        end
        compare("glitch_busy_low",   host_if.busy,      0);
        compare("glitch_rx_data",    host_if.rx_data,   8'hA5);
        compare("glitch_rx_ready",   host_if.rx_ready,  1);
        compare("glitch_frame_err",  host_if.frame_err, 0);
      end
      if (i == 4) begin
        // Acknowledge clears both the ready and the overrun flag.
        step(); host_if.rd_clr = 1'b1;
        step(); host_if.rd_clr = 1'b0;
        step();
        compare("clr_rx_ready", host_if.rx_ready, 0);
        compare("clr_overrun",  host_if.overrun,  0);
        compare("clr_rx_data",  host_if.rx_data,  8'h22);
      end
    end

    idle(10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
